// File: rtl/jpeg_frame_packager.sv
// -----------------------------------------------------------------------------
// jpeg_frame_packager
//
// Wraps a compressor's entropy-coded byte stream into a complete JPEG frame:
// the fixed header held in an external ROM, then the buffered body bytes,
// then the EOI marker (FF D9). The compressor has no backpressure, so body
// bytes arriving while the header is still going out are parked in a FIFO.
//
// Parameters
//   HEADER_LEN  number of header bytes in the ROM (>= 1)
//   FIFO_DEPTH  body FIFO depth in bytes, power of two >= 4
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous active-high reset
//   frame_start      single-cycle pulse, begins a frame (honoured in IDLE only)
//   frame_end        single-cycle pulse, compressor emitted its last byte
//   in_valid/in_data compressor byte strobe and data (already FF00-stuffed)
//   header_rom_raddr header ROM read address
//   header_rom_ren   header ROM read enable
//   header_rom_dout  ROM data, valid the cycle after header_rom_ren
//   out_valid/out_data/out_ready  output byte stream, valid/ready handshake
//   busy             high whenever a frame is in progress
//   overflow         sticky: a body byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module jpeg_frame_packager #(
    parameter int unsigned HEADER_LEN = 328,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [8:0] header_rom_raddr,
    output logic       header_rom_ren,
    input  logic [7:0] header_rom_dout,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [8:0]  HDR_LAST = 9'(HEADER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY,
        EOI_FF,
        EOI_D9
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [8:0]  hdr_addr_q, hdr_addr_d;     // next ROM address to fetch
    logic        hdr_all_q, hdr_all_d;       // last header address fetched
    logic        rom_pend_q, rom_pend_d;     // ROM data arrives this cycle
    logic        eof_q, eof_d;               // frame_end latch
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake and FIFO status
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic out_free;
    logic push_req;
    logic push;
    logic pop;
    logic rom_ren;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign accept   = out_valid_q && out_ready;
    // The output register is free to take a new byte at the next edge.
    assign out_free = !out_valid_q || out_ready;

    assign push_req = in_valid &&
                      ((state_q == HEADER) || (state_q == BODY) ||
                       ((state_q == IDLE) && frame_start));
    assign pop      = (state_q == BODY) && !fifo_empty && out_free;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign push     = push_req && (!fifo_full || pop);

    // A fetch is only issued when nothing else can claim the output register
    // on the cycle its data returns: no fetch already in flight and the
    // register either empty or being accepted now. This caps the header at
    // one byte every two cycles but never needs a skid buffer.
    assign rom_ren  = (state_q == HEADER) && !hdr_all_q && !rom_pend_q && out_free;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hdr_addr_d  = hdr_addr_q;
        hdr_all_d   = hdr_all_q;
        rom_pend_d  = rom_pend_q;
        eof_d       = eof_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_d       = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        if (((state_q == HEADER) || (state_q == BODY)) && frame_end) begin
            eof_d = 1'b1;
        end

        // An accepted byte empties the register unless reloaded below.
        if (accept) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d    = HEADER;
                    hdr_addr_d = '0;
                    hdr_all_d  = 1'b0;
                    rom_pend_d = 1'b0;
                end
            end

            HEADER: begin
                rom_pend_d = rom_ren;
                if (rom_ren) begin
                    // Saturate on the last address so raddr never runs past it.
                    if (hdr_addr_q == HDR_LAST) begin
                        hdr_all_d = 1'b1;
                    end else begin
                        hdr_addr_d = hdr_addr_q + 9'd1;
                    end
                end
                if (rom_pend_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = header_rom_dout;
                end else if (hdr_all_q && accept) begin
                    // With every fetch done and none in flight, the byte
                    // being accepted is the last header byte.
                    state_d = BODY;
                end
            end

            BODY: begin
                if (pop) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                end else if (eof_q && fifo_empty && !push && out_free) begin
                    state_d     = EOI_FF;
                    out_valid_d = 1'b1;
                    out_data_d  = 8'hFF;
                end
            end

            EOI_FF: begin
                if (accept) begin
                    state_d     = EOI_D9;
                    out_valid_d = 1'b1;
                    out_data_d  = 8'hD9;
                end
            end

            EOI_D9: begin
                if (accept) begin
                    state_d = IDLE;
                    eof_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            hdr_addr_q  <= '0;
            hdr_all_q   <= 1'b0;
            rom_pend_q  <= 1'b0;
            eof_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_addr_q  <= hdr_addr_d;
            hdr_all_q   <= hdr_all_d;
            rom_pend_q  <= rom_pend_d;
            eof_q       <= eof_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage needs no reset; the pointers define its contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign header_rom_raddr = hdr_addr_q;
    assign header_rom_ren   = rom_ren;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign busy             = (state_q != IDLE);
    assign overflow         = ovf_q;

endmodule
